// File: rtl/seq_detector_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : seq_detector_arbiter
// Description : Round-robin frame arbiter that shares one 3-bit sequence
//               detector among N_SRC symbol sources. One source is granted
//               per frame. Its symbols are forwarded on a registered stream.
//               A FILL symbol separates frames so that a match can never span
//               two frames or two sources. Detector hits are attributed to the
//               owning source, and stalled frames are aborted after TIMEOUT
//               idle cycles.
//               Optional per-source hit counters: define SEQDET_HIT_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_detector_arbiter #(
   parameter int N_SRC   = 4,
   parameter int SRC_W   = 2,
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 8
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [N_SRC-1:0]         req_valid,
   input  logic [3*N_SRC-1:0]       req_data,
   input  logic [N_SRC-1:0]         req_last,
   output logic [N_SRC-1:0]         req_ready,
   output logic [2:0]               det_data,
   input  logic                     det_found,
   output logic                     hit_valid,
   output logic [SRC_W-1:0]         hit_src,
   output logic                     abort,
   output logic                     busy,
   output logic [SRC_W-1:0]         grant_src,
   output logic [N_SRC*CNT_W-1:0]   hit_cnt
);

   // FILL is absent from the target pattern, so one FILL resets any partial match
   localparam logic [2:0] FILL   = 3'b111;
   localparam int         IDLE_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_XFER  = 2'd1,
      S_FLUSH = 2'd2
   } state_t;

   state_t              state;
   logic [SRC_W-1:0]    rr_ptr;
   logic [IDLE_W-1:0]   idle_cnt;
   logic [2:0]          src_sym [N_SRC];
   logic                accept;
   logic                any_req;
   logic                last_sym;
   logic                idle_hit;
   logic [SRC_W-1:0]    flush_ptr;
   logic [SRC_W-1:0]    pick_idle;
   logic [SRC_W-1:0]    pick_flush;
   logic                tag1_v;
   logic [SRC_W-1:0]    tag1;
   logic                tag2_v;
   logic [SRC_W-1:0]    tag2;

   // first valid requester at or after base, wrapping around the source ring
   function automatic logic [SRC_W-1:0] pick(input logic [N_SRC-1:0] v,
                                             input logic [SRC_W-1:0] base);
      logic [SRC_W-1:0] sel;
      logic [N_SRC-1:0] vs;
      int               j;
      sel = base;
      for (int k = N_SRC - 1; k >= 0; k--) begin
         j  = (int'(base) + k) % N_SRC;
         vs = v >> j;
         if (vs[0]) sel = SRC_W'(j);
      end
      return sel;
   endfunction

   function automatic logic [N_SRC-1:0] onehot(input logic [SRC_W-1:0] idx);
      return N_SRC'(1) << idx;
   endfunction

   for (genvar i = 0; i < N_SRC; i++) begin : g_unpack
      assign src_sym[i] = req_data[3*i +: 3];
   end

   assign accept     = |(req_valid & req_ready);
   assign any_req    = |req_valid;
   assign last_sym   = req_last[grant_src];
   assign idle_hit   = (idle_cnt == IDLE_W'(TIMEOUT - 1));
   assign flush_ptr  = (grant_src == SRC_W'(N_SRC - 1)) ? '0 : grant_src + 1'b1;
   assign pick_idle  = pick(req_valid, rr_ptr);
   assign pick_flush = pick(req_valid, flush_ptr);

   // frame control: grant, transfer, timeout abort and one-cycle flush
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= S_IDLE;
         rr_ptr    <= '0;
         grant_src <= '0;
         req_ready <= '0;
         busy      <= 1'b0;
         abort     <= 1'b0;
         idle_cnt  <= '0;
      end else begin
         abort <= 1'b0;
         case (state)
            S_IDLE: begin
               if (any_req) begin
                  grant_src <= pick_idle;
                  req_ready <= onehot(pick_idle);
                  busy      <= 1'b1;
                  idle_cnt  <= '0;
                  state     <= S_XFER;
               end
            end
            S_XFER: begin
               if (accept) begin
                  idle_cnt <= '0;
                  if (last_sym) begin
                     req_ready <= '0;
                     state     <= S_FLUSH;
                  end
               end else if (idle_hit) begin
                  abort     <= 1'b1;
                  req_ready <= '0;
                  idle_cnt  <= '0;
                  state     <= S_FLUSH;
               end else begin
                  idle_cnt <= idle_cnt + 1'b1;
               end
            end
            S_FLUSH: begin
               rr_ptr <= flush_ptr;
               if (any_req) begin
                  grant_src <= pick_flush;
                  req_ready <= onehot(pick_flush);
                  idle_cnt  <= '0;
                  state     <= S_XFER;
               end else begin
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // forward the accepted symbol with its owner tag; every other cycle sends FILL
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         det_data <= FILL;
         tag1_v   <= 1'b0;
         tag1     <= '0;
      end else begin
         det_data <= accept ? src_sym[grant_src] : FILL;
         tag1_v   <= accept;
         tag1     <= grant_src;
      end
   end

   // delay the tag to line up with det_found, then attribute the hit
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tag2_v    <= 1'b0;
         tag2      <= '0;
         hit_valid <= 1'b0;
         hit_src   <= '0;
      end else begin
         tag2_v    <= tag1_v;
         tag2      <= tag1;
         hit_valid <= det_found & tag2_v;
         hit_src   <= tag2;
      end
   end

`ifdef SEQDET_HIT_CNT_EN
   for (genvar i = 0; i < N_SRC; i++) begin : g_hit_cnt
      logic [CNT_W-1:0] cnt;
      // saturating count of hits owned by this source
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            cnt <= '0;
         end else if (hit_valid && (hit_src == SRC_W'(i)) && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
         end
      end
      assign hit_cnt[i*CNT_W +: CNT_W] = cnt;
   end
`else
   assign hit_cnt = '0;
`endif

endmodule
`default_nettype wire
